// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   STATE_W : width of the debug state output
//   state_e : sequencer FSM states (encoding is visible on the state port)
package reset_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Single-bit multi-flop synchroniser with a selectable reset value.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, loads RST_VAL into every stage
//   d       : asynchronous input
//   q       : synchronised output (last stage)
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges the reset button, clock-generator lock flags and a
// software request into one reset cause, holds every domain in reset until the
// cause has been clear for HOLD_CYCLES, then releases domains in index order
// STAGGER cycles apart.
//   clk           : system clock
//   reset_n       : asynchronous active-low reset of the sequencer itself
//   reset_in      : asynchronous active-high external reset button
//   locked        : asynchronous clock-generator lock flags (1 = locked)
//   sw_reset      : synchronous single-cycle software reset request
//   lock_lost_clr : synchronous pulse clearing lock_lost
//   rst_out       : registered active-high domain resets, bit 0 released first
//   ready         : registered, high once every domain is released
//   lock_lost     : sticky flag, a lock dropped while running
//   state         : FSM state for debug
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_LOCKS   = 2,
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16777215,
    parameter int STAGGER     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   reset_in,
    input  logic [NUM_LOCKS-1:0]   locked,
    input  logic                   sw_reset,
    input  logic                   lock_lost_clr,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [STATE_W-1:0]     state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STAG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(1);

    // Synchronisers: the button resets to "pressed" and the locks to
    // "unlocked", so the sequencer cannot start counting until real input
    // values have propagated through every stage.
    logic                 reset_s;
    logic [NUM_LOCKS-1:0] locked_s;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_reset (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (reset_in),
        .q       (reset_s)
    );

    for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_lock_sync
        sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lock (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (locked[i]),
            .q       (locked_s[i])
        );
    end

    logic lock_drop;
    logic cause;

    assign lock_drop = ~&locked_s;
    assign cause     = reset_s | lock_drop | sw_reset;

    state_e                 state_q, state_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    always_comb begin
        state_d     = state_q;
        rst_out_d   = rst_out_q;
        ready_d     = ready_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        idx_d       = idx_q;
        lock_lost_d = lock_lost_q;

        // Clear first so a simultaneous set overrides it.
        if (lock_lost_clr) begin
            lock_lost_d = 1'b0;
        end
        if (state_q == ST_RUN && lock_drop) begin
            lock_lost_d = 1'b1;
        end

        if (cause) begin
            // Any cause restarts the whole sequence from HOLD.
            state_d    = ST_HOLD;
            rst_out_d  = '1;
            ready_d    = 1'b0;
            hold_cnt_d = '0;
            stag_cnt_d = '0;
            idx_d      = IDX_FIRST;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    state_d    = ST_COUNT;
                    hold_cnt_d = '0;
                end
                ST_COUNT: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        stag_cnt_d   = '0;
                        idx_d        = IDX_FIRST;
                        if (NUM_DOMAINS == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (stag_cnt_q == STAG_LAST) begin
                        rst_out_d[idx_q] = 1'b0;
                        stag_cnt_d       = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        stag_cnt_d = stag_cnt_q + STAG_W'(1);
                    end
                end
                ST_RUN: begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            hold_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            idx_q       <= IDX_FIRST;
        end else begin
            state_q     <= state_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            hold_cnt_q  <= hold_cnt_d;
            stag_cnt_q  <= stag_cnt_d;
            idx_q       <= idx_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with NUM_LOCKS=2, NUM_DOMAINS=3,
// HOLD_CYCLES=16, STAGGER=4, SYNC_STAGES=2. Inputs are driven and outputs
// sampled 1 ns after each rising edge; "edge n" below counts rising edges
// after the stimulus change of each scenario.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       reset_in;
    logic [1:0] locked;
    logic       sw_reset;
    logic       lock_lost_clr;
    logic [2:0] rst_out;
    logic       ready;
    logic       lock_lost;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_LOCKS   (2),
        .NUM_DOMAINS (3),
        .HOLD_CYCLES (16),
        .STAGGER     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .reset_in      (reset_in),
        .locked        (locked),
        .sw_reset      (sw_reset),
        .lock_lost_clr (lock_lost_clr),
        .rst_out       (rst_out),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .state         (state)
    );

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Reset held 5 cycles, then release: bit0 at edge 19, bit1 23, bit2 27.
    task automatic test_power_up();
        logic [2:0] exp_rst;
        logic [1:0] exp_state;
        logic       exp_ready;
        reset_n       = 1'b0;
        reset_in      = 1'b0;
        locked        = 2'b11;
        sw_reset      = 1'b0;
        lock_lost_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            n_checks++;
            if (rst_out !== 3'b111 || ready !== 1'b0 || state !== 2'd0 || lock_lost !== 1'b0) begin
                n_fail++;
                $display("FAIL power_up_in_reset cyc %0d: rst_out=%b ready=%b state=%0d lock_lost=%b, expected 111 0 0 0",
                         i, rst_out, ready, state, lock_lost);
            end
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            edge_step();
            exp_rst   = {n < 27, n < 23, n < 19};
            exp_ready = (n >= 27);
            exp_state = (n < 3) ? 2'd0 : (n < 19) ? 2'd1 : (n < 27) ? 2'd2 : 2'd3;
            n_checks++;
            if (rst_out !== exp_rst || ready !== exp_ready || state !== exp_state) begin
                n_fail++;
                $display("FAIL power_up edge %0d: rst_out=%b ready=%b state=%0d, expected %b %b %0d",
                         n, rst_out, ready, state, exp_rst, exp_ready, exp_state);
            end
        end
    endtask

    // Button pulse for one cycle in RUN: HOLD at edge 3, bit0 at edge 20.
    task automatic test_button();
        logic [2:0] exp_rst;
        logic       exp_ready;
        reset_in = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            edge_step();
            if (n == 1) reset_in = 1'b0;
            exp_rst   = (n < 3) ? 3'b000 : {n < 28, n < 24, n < 20};
            exp_ready = (n < 3) || (n >= 28);
            n_checks++;
            if (rst_out !== exp_rst || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL button edge %0d: rst_out=%b ready=%b, expected %b %b",
                         n, rst_out, ready, exp_rst, exp_ready);
            end
        end
    endtask

    // locked[1] low for 10 cycles: HOLD + lock_lost at edge 3, bit0 at 29.
    task automatic test_lock_loss();
        logic [2:0] exp_rst;
        logic       exp_ready;
        logic       exp_ll;
        locked[1] = 1'b0;
        for (int n = 1; n <= 37; n++) begin
            edge_step();
            if (n == 10) locked[1] = 1'b1;
            exp_rst   = (n < 3) ? 3'b000 : {n < 37, n < 33, n < 29};
            exp_ready = (n < 3) || (n >= 37);
            exp_ll    = (n >= 3);
            n_checks++;
            if (rst_out !== exp_rst || ready !== exp_ready || lock_lost !== exp_ll) begin
                n_fail++;
                $display("FAIL lock_loss edge %0d: rst_out=%b ready=%b lock_lost=%b, expected %b %b %b",
                         n, rst_out, ready, lock_lost, exp_rst, exp_ready, exp_ll);
            end
        end
        lock_lost_clr = 1'b1;
        edge_step();
        lock_lost_clr = 1'b0;
        n_checks++;
        if (lock_lost !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_lost_clear: lock_lost=%b ready=%b, expected 0 1", lock_lost, ready);
        end
    endtask

    // sw_reset in RUN, then again right after bit0 is released (edge 18).
    task automatic test_sw_mid_release();
        logic [2:0] exp_rst;
        logic [1:0] exp_state;
        logic       exp_ready;
        sw_reset = 1'b1;
        for (int n = 1; n <= 44; n++) begin
            edge_step();
            sw_reset = (n == 18);
            exp_rst   = (n < 18) ? 3'b111 : (n == 18) ? 3'b110 : {n < 44, n < 40, n < 36};
            exp_ready = (n == 44);
            exp_state = (n == 1 || n == 19) ? 2'd0 :
                        (n < 18 || (n > 19 && n < 36)) ? 2'd1 :
                        (n < 44) ? 2'd2 : 2'd3;
            n_checks++;
            if (rst_out !== exp_rst || ready !== exp_ready || state !== exp_state) begin
                n_fail++;
                $display("FAIL sw_mid_release edge %0d: rst_out=%b ready=%b state=%0d, expected %b %b %0d",
                         n, rst_out, ready, state, exp_rst, exp_ready, exp_state);
            end
        end
    endtask

    // Enter COUNT via sw_reset, glitch locked[0] at count 10; HOLD at edge 15,
    // count restarts at 16, bit0 not before edge 32.
    task automatic test_cause_during_count();
        logic [2:0] exp_rst;
        logic [1:0] exp_state;
        logic       exp_ready;
        sw_reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            edge_step();
            if (n == 1)  sw_reset  = 1'b0;
            if (n == 12) locked[0] = 1'b0;
            if (n == 13) locked[0] = 1'b1;
            exp_rst   = {n < 40, n < 36, n < 32};
            exp_ready = (n == 40);
            exp_state = (n == 1 || n == 15) ? 2'd0 :
                        (n < 32) ? 2'd1 :
                        (n < 40) ? 2'd2 : 2'd3;
            n_checks++;
            if (rst_out !== exp_rst || ready !== exp_ready || state !== exp_state) begin
                n_fail++;
                $display("FAIL cause_during_count edge %0d: rst_out=%b ready=%b state=%0d, expected %b %b %0d",
                         n, rst_out, ready, state, exp_rst, exp_ready, exp_state);
            end
        end
    endtask

    // lock_lost_clr lands on the same edge that sets lock_lost (edge 3).
    task automatic test_collision();
        logic [2:0] exp_rst;
        locked[0] = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            edge_step();
            if (n == 1) locked[0] = 1'b1;
            lock_lost_clr = (n == 2);
            exp_rst = (n < 3) ? 3'b000 : {n < 28, n < 24, n < 20};
            n_checks++;
            if (lock_lost !== (n >= 3) || rst_out !== exp_rst) begin
                n_fail++;
                $display("FAIL collision edge %0d: lock_lost=%b rst_out=%b, expected %b %b",
                         n, lock_lost, rst_out, (n >= 3), exp_rst);
            end
        end
    endtask

    // reset_n low between edges must assert everything without a clock.
    task automatic test_async_reset();
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0 || state !== 2'd0 || lock_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: rst_out=%b ready=%b state=%0d lock_lost=%b, expected 111 0 0 0",
                     rst_out, ready, state, lock_lost);
        end
        edge_step();
        reset_n = 1'b1;
    endtask

    initial begin
        test_power_up();
        test_button();
        test_lock_loss();
        test_sw_mid_release();
        test_cause_during_count();
        test_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

endmodule
